// File: rtl/seq_set_less_than.sv
// seq_set_less_than: multi-cycle SLT/SLTU compare unit.
// Scans the operands MSB-first, CHUNK bits per cycle, behind a start/done
// handshake. Optional build macro SLT_EARLY_EXIT_EN: when defined, the scan
// ends on the first differing chunk; otherwise latency is fixed at NCHUNK+1.
module seq_set_less_than #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             eq,
    output logic             ge
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [IDXW-1:0]   idx;
    logic              decided, less_acc;
    logic [CHUNK-1:0]  chunk_a, chunk_b;
    logic              chunk_diff, dec_nxt, lacc_nxt, scan_exit, accept;

    // Current chunk of each operand, selected by the down-counting index
    assign chunk_a    = a_q[int'(idx)*CHUNK +: CHUNK];
    assign chunk_b    = b_q[int'(idx)*CHUNK +: CHUNK];
    assign chunk_diff = (chunk_a != chunk_b);

    // The first differing chunk decides; later chunks never override it
    assign dec_nxt  = decided | chunk_diff;
    assign lacc_nxt = decided ? less_acc : (chunk_diff & (chunk_a < chunk_b));

`ifdef SLT_EARLY_EXIT_EN
    assign scan_exit = (idx == '0) | chunk_diff;
`else
    assign scan_exit = (idx == '0);
`endif

    // A new request is taken in IDLE, or in DONE for back-to-back issue
    assign accept = start && ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (scan_exit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, chunk scan, and result registers (loaded on SCAN exit
    // so they are valid in the DONE cycle and held until the next one)
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            decided  <= 1'b0;
            less_acc <= 1'b0;
            less     <= 1'b0;
            eq       <= 1'b0;
            ge       <= 1'b0;
        end else if (accept) begin
            // Flipping the sign bits maps two's complement order onto unsigned order
            a_q      <= {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
            b_q      <= {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};
            idx      <= IDXW'(NCHUNK - 1);
            decided  <= 1'b0;
            less_acc <= 1'b0;
        end else if (state == SCAN) begin
            decided  <= dec_nxt;
            less_acc <= lacc_nxt;
            if (idx != '0) idx <= idx - IDXW'(1);
            if (scan_exit) begin
                less <= dec_nxt & lacc_nxt;
                eq   <= ~dec_nxt;
                ge   <= ~(dec_nxt & lacc_nxt);
            end
        end
    end
endmodule

// File: tb/tb_seq_set_less_than.sv
// Directed bench for seq_set_less_than; latency expectations follow the
// SLT_EARLY_EXIT_EN build macro.
module tb_seq_set_less_than;
    logic        clk = 1'b0;
    logic        reset, start, is_signed;
    logic [63:0] a, b;
    logic        busy, done, less, eq, ge;

    int checks = 0;
    int errors = 0;

`ifdef SLT_EARLY_EXIT_EN
    localparam int LAT_TOP = 2;
`else
    localparam int LAT_TOP = 9;
`endif
    localparam int LAT_FULL = 9;

    seq_set_less_than #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .less(less), .eq(eq), .ge(ge)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a posedge: drives a request for the current cycle
    task automatic launch(input logic [63:0] va, input logic [63:0] vb, input logic sg);
        start = 1'b1; a = va; b = vb; is_signed = sg;
    endtask

    // Counts cycles from the accepting edge until done, bounded
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                          input logic sg, input int exp_lat,
                          input logic e_less, input logic e_eq, input logic e_ge);
        int lat;
        launch(va, vb, sg);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_less"}, 64'(less), 64'(e_less));
        chk({tag, "_eq"}, 64'(eq), 64'(e_eq));
        chk({tag, "_ge"}, 64'(ge), 64'(e_ge));
        @(posedge clk); #1;
        chk({tag, "_done1"}, 64'(done), 64'd0);
    endtask

    initial begin
        int ndone, dcyc, lat;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_less", 64'(less), 64'd0);
        chk("rst_eq",   64'(eq),   64'd0);
        chk("rst_ge",   64'(ge),   64'd0);
        @(posedge clk); #1;

        run_op("u5_7",    64'h5, 64'h7, 1'b0, LAT_FULL, 1'b1, 1'b0, 1'b0);
        run_op("u_m1_1",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, LAT_TOP, 1'b0, 1'b0, 1'b1);
        run_op("s_m1_1",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, LAT_TOP, 1'b1, 1'b0, 1'b0);
        run_op("s_eq",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
               LAT_FULL, 1'b0, 1'b1, 1'b1);
        run_op("u_top",   64'h0100_0000_0000_0000, 64'h0200_0000_0000_0000, 1'b0,
               LAT_TOP, 1'b1, 1'b0, 1'b0);
        run_op("s_mid",   64'h0000_0012_0000_0000, 64'hFFFF_FF34_0000_0000, 1'b1,
               LAT_TOP, 1'b0, 1'b0, 1'b1);

        // Start held during SCAN cycles 2..5 must be ignored
        launch(64'h5, 64'h7, 1'b0);
        ndone = 0; dcyc = -1;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; dcyc = n; end
            if (n == 1) start = 1'b0;
            if (n == 2) begin start = 1'b1; a = 64'h9; b = 64'h1; end
            if (n == 6) start = 1'b0;
        end
        chk("hs_ndone", 64'(ndone), 64'd1);
        chk("hs_cyc",   64'(dcyc),  64'd9);
        chk("hs_less",  64'(less),  64'd1);

        // Back-to-back: new start issued in the DONE cycle
        launch(64'h7, 64'h5, 1'b0);
        wait_done(lat);
        chk("b2b1_lat",  64'(lat),  64'd9);
        chk("b2b1_less", 64'(less), 64'd0);
        chk("b2b1_ge",   64'(ge),   64'd1);
        launch(64'h3, 64'h9, 1'b1);
        wait_done(lat);
        chk("b2b2_lat",  64'(lat),  64'd9);
        chk("b2b2_less", 64'(less), 64'd1);
        chk("b2b2_ge",   64'(ge),   64'd0);
        @(posedge clk); #1;

        // Reset during SCAN cycle 4 drops the operation
        launch(64'h5, 64'h7, 1'b0);
        ndone = 0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (done) ndone++;
        end
        chk("mid_busy4", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_less", 64'(less), 64'd0);
        chk("mid_eq",   64'(eq),   64'd0);
        chk("mid_ge",   64'(ge),   64'd0);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid_nodone", 64'(ndone), 64'd0);
        run_op("post_rst", 64'h0100_0000_0000_0000, 64'h0200_0000_0000_0000, 1'b0,
               LAT_TOP, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_set_less_than.md
# seq_set_less_than

Multi-cycle SLT/SLTU compare unit for the RISC-V datapath. It accepts two 64-bit operands through a start/done handshake and scans them MSB-first, CHUNK bits per cycle. It then reports less-than, equal and greater-or-equal in signed or unsigned mode. It serves the issue-side requester that retires SLT/SLTU/SLTI/SLTIU and branch compares, where the single-cycle compare path is too long for the target clock.

## Interface
- WIDTH, 64, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per SCAN cycle; NCHUNK = WIDTH/CHUNK.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted when busy=0.
- is_signed  in  1  1 = SLT (two's complement), 0 = SLTU; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse; results valid from this cycle.
- less  out  1  a < b.
- eq  out  1  a == b.
- ge  out  1  a >= b, always equal to ~less once done has pulsed.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: start=1 latches a, b and is_signed into internal registers, sets the chunk index to NCHUNK-1 (top chunk) and moves to SCAN.
- Signed mode: invert the MSB of both latched operands at capture. After that the compare is unsigned.
- SCAN: each cycle compares the current chunk of A and B.
  - First differing chunk: record decided=1 and less_acc = (chunkA < chunkB) unsigned. Later chunks cannot change an already-decided result.
  - Chunk index decrements by 1 per cycle. Leave for DONE after chunk 0 is processed.
- DONE: registers the outputs.
  - less = decided & less_acc.
  - eq = ~decided.
  - ge = ~less.
  - done=1 for exactly this cycle.
  - Next state is IDLE, or SCAN if start=1 in this cycle (back-to-back).
- Results less/eq/ge hold their value until the next DONE cycle or reset.
- start while busy=1 is ignored. There is no queueing; the requester must retry.
- Operand inputs are don't-care except in the accepting cycle.

## Timing
- Reset values: state IDLE, busy=0, done=0, less=0, eq=0, ge=0, internal operand registers 0.
- Reset mid-SCAN or in DONE: returns to IDLE next edge. No done pulse; the in-flight result is lost.
- Reset has priority over start in the same cycle.
- Start accepted in cycle 0 (edge at end of cycle 0):
  - cycles 1..NCHUNK: busy=1.
  - cycle NCHUNK+1: done=1, busy=0.
  - Default latency start-to-done: 9 cycles.
- busy and done are never high together.
- Throughput with back-to-back start in DONE: one result per NCHUNK+1 cycles.

## Configuration
- Macro SLT_EARLY_EXIT_EN.
- Defined: SCAN leaves for DONE on the cycle the first differing chunk is found. Latency is (k+1) for a difference in the k-th chunk examined counting from 1; minimum is 2 cycles (top chunk differs). Equal operands still take NCHUNK+1 cycles.
- Undefined: fixed latency of NCHUNK+1 for every operand pair.
- Result values are identical in both builds.

## Test plan
- Reset, then sweep: after reset release all outputs 0; then a=0x0000_0000_0000_0005, b=0x0000_0000_0000_0007, unsigned -> done at cycle 9, less=1, eq=0, ge=0.
- Signed vs unsigned: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1.
  - is_signed=0 -> less=0, ge=1.
  - is_signed=1 -> less=1, ge=0.
- Equal operands: a=b=0x8000_0000_0000_0000, signed -> eq=1, less=0, ge=1. Latency 9 in both builds.
- Early exit, SLT_EARLY_EXIT_EN defined: a=0x0100_0000_0000_0000, b=0x0200_0000_0000_0000, unsigned -> done at cycle 2, less=1. Same stimulus without the macro -> done at cycle 9.
- Handshake: start held high in cycles 2..5 of a busy op is ignored (single done). Start asserted in the DONE cycle with new operands is accepted, and the second done arrives 9 cycles later.
- Reset at cycle 4 of SCAN: no done pulse, busy=0 next cycle, outputs 0. A new start after reset completes normally.
